// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - response codes and FSM state types for the AXI4-Lite register slave
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4l_reg_slave_wrfsm.sv
// rtl/axi4l_reg_slave_wrfsm.sv - AW/W capture, address decode and write-response FSM
// Optional feature: AXI4L_REG_SLAVE_PROT_EN rejects unprivileged writes with SLVERR.
module axi4l_reg_slave_wrfsm
  import axi4l_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OFF_W    = $clog2(DATA_W / 8),
  parameter int IDX_W    = ADDR_W - OFF_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_W-1:0]     i_awaddr,
  input  logic [2:0]            i_awprot,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_wr_en,
  output logic [IDX_W-1:0]      o_wr_idx,
  output logic [DATA_W-1:0]     o_wr_data,
  output logic [DATA_W/8-1:0]   o_wr_strb
);

  localparam logic [IDX_W:0] LP_NUM_REGS = (IDX_W + 1)'(NUM_REGS);

  wr_state_e             r_state;
  wr_state_e             w_state_nxt;
  logic                  r_live;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_W-1:0]     r_awaddr;
  logic [2:0]            r_awprot;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  resp_e                 r_bresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic                  w_in_range;
  logic                  w_prot_ok;
  logic [ADDR_W-1:0]     w_addr;
  logic [2:0]            w_prot;
  logic                  w_unused;

  // r_live keeps the READYs low through reset and raises them on the first edge after
  assign o_awready = r_live && (r_state == W_IDLE) && !r_aw_held;
  assign o_wready  = r_live && (r_state == W_IDLE) && !r_w_held;
  assign w_aw_hs   = i_awvalid && o_awready;
  assign w_w_hs    = i_wvalid && o_wready;

  // A channel arriving on the commit edge is used directly, otherwise its latched copy
  assign w_addr    = r_aw_held ? r_awaddr : i_awaddr;
  assign w_prot    = r_aw_held ? r_awprot : i_awprot;
  assign o_wr_data = r_w_held ? r_wdata : i_wdata;
  assign o_wr_strb = r_w_held ? r_wstrb : i_wstrb;
  assign o_wr_idx  = w_addr[ADDR_W-1:OFF_W];

  assign w_in_range = ({1'b0, o_wr_idx} < LP_NUM_REGS);
`ifdef AXI4L_REG_SLAVE_PROT_EN
  assign w_prot_ok  = w_prot[0];
`else
  assign w_prot_ok  = 1'b1;
`endif

  assign w_commit = (r_state == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign o_wr_en  = w_commit && w_in_range && w_prot_ok;
  assign o_bvalid = (r_state == W_RESP);
  assign o_bresp  = r_bresp;
  assign w_unused = ^{w_prot, w_addr[OFF_W-1:0]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE:  if (w_commit) w_state_nxt = W_RESP;
      W_RESP:  if (i_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= W_IDLE;
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_awprot  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= OKAY;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= (w_in_range && w_prot_ok) ? OKAY : SLVERR;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
      end
      if (w_aw_hs) begin
        r_awaddr <= i_awaddr;
        r_awprot <= i_awprot;
      end
      if (w_w_hs) begin
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end
    end
  end

endmodule

// File: rtl/axi4l_reg_slave.sv
// rtl/axi4l_reg_slave.sv - AXI4-Lite register file: storage, write pulses and read path
// Optional feature: AXI4L_REG_SLAVE_PROT_EN (handled in the write FSM sub-module).
module axi4l_reg_slave
  import axi4l_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic [2:0]                   AWPROT,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic [DATA_W/8-1:0]          WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic [2:0]                   ARPROT,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int             OFF_W       = $clog2(DATA_W / 8);
  localparam int             IDX_W       = ADDR_W - OFF_W;
  localparam logic [IDX_W:0] LP_NUM_REGS = (IDX_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;
  rd_state_e             r_rstate;
  rd_state_e             w_rstate_nxt;
  logic                  r_live;
  logic [DATA_W-1:0]     r_rdata;
  resp_e                 r_rresp;

  logic                  w_wr_en;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [DATA_W-1:0]     w_wr_data;
  logic [DATA_W/8-1:0]   w_wr_strb;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_ar_hs;
  logic                  w_ar_in_range;
  logic [DATA_W-1:0]     w_rd_mux;
  logic                  w_unused;

  axi4l_reg_slave_wrfsm #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .OFF_W    (OFF_W),
    .IDX_W    (IDX_W)
  ) u_wrfsm (
    .i_clk     (ACLK),
    .i_rst_n   (ARESETN),
    .i_awaddr  (AWADDR),
    .i_awprot  (AWPROT),
    .i_awvalid (AWVALID),
    .o_awready (AWREADY),
    .i_wdata   (WDATA),
    .i_wstrb   (WSTRB),
    .i_wvalid  (WVALID),
    .o_wready  (WREADY),
    .o_bresp   (BRESP),
    .o_bvalid  (BVALID),
    .i_bready  (BREADY),
    .o_wr_en   (w_wr_en),
    .o_wr_idx  (w_wr_idx),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en && (w_wr_idx == IDX_W'(i))) begin
          r_wr_pulse[i] <= 1'b1;
          for (int b = 0; b < DATA_W / 8; b++) begin
            if (w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
  end
  assign wr_pulse_o = r_wr_pulse;

  assign ARREADY       = r_live && (r_rstate == R_IDLE);
  assign w_ar_hs       = ARVALID && ARREADY;
  assign w_ar_idx      = ARADDR[ADDR_W-1:OFF_W];
  assign w_ar_in_range = ({1'b0, w_ar_idx} < LP_NUM_REGS);
  assign RVALID        = (r_rstate == R_DATA);
  assign RDATA         = r_rdata;
  assign RRESP         = r_rresp;
  assign w_unused      = ^{ARPROT, ARADDR[OFF_W-1:0]};

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) w_rd_mux = r_regs[i];
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (RREADY)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read data is sampled from storage before any same-edge write lands
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate <= R_IDLE;
      r_live   <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_live   <= 1'b1;
      if (w_ar_hs) begin
        r_rdata <= w_ar_in_range ? w_rd_mux : '0;
        r_rresp <= w_ar_in_range ? OKAY : SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// tb/tb_axi4l_reg_slave.sv - randomized self-checking bench with a register-array reference model
module tb_axi4l_reg_slave;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  logic                        ACLK = 1'b0;
  logic                        ARESETN;
  logic [ADDR_W-1:0]           AWADDR;
  logic [2:0]                  AWPROT;
  logic                        AWVALID;
  logic                        AWREADY;
  logic [DATA_W-1:0]           WDATA;
  logic [DATA_W/8-1:0]         WSTRB;
  logic                        WVALID;
  logic                        WREADY;
  logic [1:0]                  BRESP;
  logic                        BVALID;
  logic                        BREADY;
  logic [ADDR_W-1:0]           ARADDR;
  logic [2:0]                  ARPROT;
  logic                        ARVALID;
  logic                        ARREADY;
  logic [DATA_W-1:0]           RDATA;
  logic [1:0]                  RRESP;
  logic                        RVALID;
  logic                        RREADY;
  logic [NUM_REGS*DATA_W-1:0]  regs_o;
  logic [NUM_REGS-1:0]         wr_pulse_o;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] m_regs [NUM_REGS];

  always #5 ACLK = ~ACLK;

  axi4l_reg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  function automatic logic [1:0] model_wresp(input logic [11:0] addr, input logic [2:0] prot);
    if ((addr >> 2) >= NUM_REGS) return 2'b10;
`ifdef AXI4L_REG_SLAVE_PROT_EN
    if (prot[0] == 1'b0) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic logic [15:0] model_write(input logic [11:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb, input logic [2:0] prot);
    int idx;
    idx = int'(addr >> 2);
    if (model_wresp(addr, prot) != 2'b00) return 16'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
    return 16'(1) << idx;
  endfunction

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = m_regs[i];
    return f;
  endfunction

  task automatic start_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, input int aw_dly, input int w_dly,
                             output logic [15:0] pulse);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && c < 64) begin
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      c++;
    end
    AWVALID = 0; WVALID = 0;
    c = 0;
    while (!BVALID && c < 8) begin
      @(posedge ACLK); #1;
      c++;
    end
    checks++;
    if (!(aw_done && w_done && BVALID)) begin
      errors++;
      $display("FAIL write_handshake addr=%h got bvalid=%b required 1", addr, BVALID);
    end
    pulse = wr_pulse_o;
  endtask

  task automatic finish_write(output logic [1:0] resp);
    resp = BRESP;
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
  endtask

  task automatic start_read(input logic [11:0] addr);
    bit done, hs;
    int c;
    done = 0; c = 0;
    ARADDR = addr;
    while (!done && c < 64) begin
      ARVALID = 1;
      hs = ARREADY;
      @(posedge ACLK); #1;
      if (hs) done = 1;
      c++;
    end
    ARVALID = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL read_handshake addr=%h got arready=%b required 1", addr, ARREADY);
    end
  endtask

  task automatic finish_read(output logic [31:0] data, output logic [1:0] resp);
    int c;
    c = 0;
    while (!RVALID && c < 8) begin
      @(posedge ACLK); #1;
      c++;
    end
    checks++;
    if (!RVALID) begin
      errors++;
      $display("FAIL read_valid got rvalid=%b required 1", RVALID);
    end
    data = RDATA; resp = RRESP;
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
  endtask

  task automatic test_reset();
    ARESETN = 0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake got %b required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if (regs_o !== model_flat() || wr_pulse_o !== '0) begin
      errors++;
      $display("FAIL reset_regs got pulse=%h required 0000", wr_pulse_o);
    end
    checks++;
    if (RDATA !== '0 || BRESP !== 2'b00 || RRESP !== 2'b00) begin
      errors++;
      $display("FAIL reset_payload got rdata=%h bresp=%b rresp=%b required 0", RDATA, BRESP, RRESP);
    end
    @(negedge ACLK);
    ARESETN = 1;
    @(posedge ACLK); #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_basic_write();
    logic [15:0] pulse, exp_pulse;
    logic [1:0] resp;
    start_write(12'h004, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, pulse);
    exp_pulse = model_write(12'h004, 32'hDEADBEEF, 4'hF, 3'b001);
    checks++;
    if (pulse !== exp_pulse) begin
      errors++;
      $display("FAIL basic_pulse got %h required %h", pulse, exp_pulse);
    end
    finish_write(resp);
    checks++;
    if (resp !== 2'b00) begin
      errors++;
      $display("FAIL basic_bresp got %b required 00", resp);
    end
    checks++;
    if (wr_pulse_o !== '0) begin
      errors++;
      $display("FAIL basic_pulse_width got %h required 0000", wr_pulse_o);
    end
    checks++;
    if (regs_o[1*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_reg1 got %h required deadbeef", regs_o[1*DATA_W +: DATA_W]);
    end
  endtask

  task automatic test_w_before_aw();
    logic [15:0] pulse;
    logic [1:0] resp;
    bit extra_b;
    start_write(12'h008, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 0, pulse);
    void'(model_write(12'h008, 32'hFFFFFFFF, 4'hF, 3'b001));
    finish_write(resp);
    start_write(12'h008, 32'h12345678, 4'h3, 3'b001, 3, 0, pulse);
    void'(model_write(12'h008, 32'h12345678, 4'h3, 3'b001));
    finish_write(resp);
    checks++;
    if (regs_o[2*DATA_W +: DATA_W] !== m_regs[2] || m_regs[2] !== 32'hFFFF5678) begin
      errors++;
      $display("FAIL w_first_reg2 got %h required ffff5678", regs_o[2*DATA_W +: DATA_W]);
    end
    checks++;
    if (resp !== 2'b00) begin
      errors++;
      $display("FAIL w_first_bresp got %b required 00", resp);
    end
    extra_b = 0;
    for (int i = 0; i < 3; i++) begin
      if (BVALID !== 1'b0) extra_b = 1;
      @(posedge ACLK); #1;
    end
    checks++;
    if (extra_b) begin
      errors++;
      $display("FAIL w_first_single_b got extra bvalid required none");
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] pulse;
    logic [31:0] data;
    logic [1:0] resp;
    start_read(12'h040);
    finish_read(data, resp);
    checks++;
    if (resp !== 2'b10 || data !== 32'h0) begin
      errors++;
      $display("FAIL oor_read got resp=%b data=%h required 10 00000000", resp, data);
    end
    start_write(12'h040, 32'hCAFEF00D, 4'hF, 3'b001, 0, 0, pulse);
    void'(model_write(12'h040, 32'hCAFEF00D, 4'hF, 3'b001));
    finish_write(resp);
    checks++;
    if (resp !== 2'b10 || pulse !== 16'h0) begin
      errors++;
      $display("FAIL oor_write got resp=%b pulse=%h required 10 0000", resp, pulse);
    end
    checks++;
    if (regs_o !== model_flat()) begin
      errors++;
      $display("FAIL oor_regs_unchanged got reg0=%h required %h", regs_o[DATA_W-1:0], m_regs[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pulse;
    logic [31:0] wdat, data;
    logic [1:0] resp;
    bit bad_b, bad_r;
    wdat = $urandom;
    start_write(12'h00C, wdat, 4'hF, 3'b001, 0, 0, pulse);
    void'(model_write(12'h00C, wdat, 4'hF, 3'b001));
    bad_b = 0;
    for (int i = 0; i < 5; i++) begin
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) bad_b = 1;
      @(posedge ACLK); #1;
    end
    checks++;
    if (bad_b) begin
      errors++;
      $display("FAIL bp_write_hold got bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
               BVALID, BRESP, AWREADY, WREADY);
    end
    finish_write(resp);
    start_read(12'h00C);
    bad_r = 0;
    for (int i = 0; i < 5; i++) begin
      if (RVALID !== 1'b1 || RDATA !== m_regs[3] || RRESP !== 2'b00 || ARREADY !== 1'b0) bad_r = 1;
      @(posedge ACLK); #1;
    end
    checks++;
    if (bad_r) begin
      errors++;
      $display("FAIL bp_read_hold got rvalid=%b rdata=%h arready=%b required 1 %h 0",
               RVALID, RDATA, ARREADY, m_regs[3]);
    end
    finish_read(data, resp);
    checks++;
    if (data !== wdat || resp !== 2'b00) begin
      errors++;
      $display("FAIL bp_read_data got %h required %h", data, wdat);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] old_val, data;
    logic [1:0] resp;
    int c;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL same_edge_ready got %b required 111", {AWREADY, WREADY, ARREADY});
    end
    old_val = m_regs[0];
    AWADDR = 12'h000; AWPROT = 3'b001; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; ARADDR = 12'h000;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    void'(model_write(12'h000, 32'hA5A5A5A5, 4'hF, 3'b001));
    c = 0;
    while (!BVALID && c < 8) begin
      @(posedge ACLK); #1;
      c++;
    end
    finish_write(resp);
    finish_read(data, resp);
    checks++;
    if (data !== old_val || old_val !== 32'h0) begin
      errors++;
      $display("FAIL same_edge_old got %h required 00000000", data);
    end
    start_read(12'h000);
    finish_read(data, resp);
    checks++;
    if (data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL same_edge_new got %h required a5a5a5a5", data);
    end
  endtask

  task automatic test_random();
    logic [11:0] addr;
    logic [31:0] wdat, data, exp_data;
    logic [3:0] strb;
    logic [2:0] prot;
    logic [15:0] pulse, exp_pulse;
    logic [1:0] resp, exp_resp;
    for (int n = 0; n < 40; n++) begin
      addr = 12'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wdat = $urandom;
        strb = 4'($urandom_range(0, 15));
        prot = 3'($urandom_range(0, 7));
        exp_resp = model_wresp(addr, prot);
        start_write(addr, wdat, strb, prot, $urandom_range(0, 2), $urandom_range(0, 2), pulse);
        exp_pulse = model_write(addr, wdat, strb, prot);
        finish_write(resp);
        checks++;
        if (resp !== exp_resp || pulse !== exp_pulse) begin
          errors++;
          $display("FAIL rand_write addr=%h got resp=%b pulse=%h required %b %h",
                   addr, resp, pulse, exp_resp, exp_pulse);
        end
      end else begin
        ARPROT = 3'($urandom_range(0, 7));
        if ((addr >> 2) >= NUM_REGS) begin
          exp_data = '0; exp_resp = 2'b10;
        end else begin
          exp_data = m_regs[addr >> 2]; exp_resp = 2'b00;
        end
        start_read(addr);
        finish_read(data, resp);
        checks++;
        if (data !== exp_data || resp !== exp_resp) begin
          errors++;
          $display("FAIL rand_read addr=%h got %h/%b required %h/%b", addr, data, resp, exp_data, exp_resp);
        end
      end
    end
    checks++;
    if (regs_o !== model_flat()) begin
      errors++;
      $display("FAIL rand_final_regs got reg0=%h required %h", regs_o[DATA_W-1:0], m_regs[0]);
    end
  endtask

`ifdef AXI4L_REG_SLAVE_PROT_EN
  task automatic test_prot();
    logic [15:0] pulse;
    logic [1:0] resp;
    start_write(12'h014, 32'h0BADF00D, 4'hF, 3'b000, 0, 0, pulse);
    void'(model_write(12'h014, 32'h0BADF00D, 4'hF, 3'b000));
    finish_write(resp);
    checks++;
    if (resp !== 2'b10 || pulse !== 16'h0 || regs_o !== model_flat()) begin
      errors++;
      $display("FAIL prot_unpriv got resp=%b pulse=%h required 10 0000", resp, pulse);
    end
    start_write(12'h014, 32'h600DF00D, 4'hF, 3'b001, 0, 0, pulse);
    void'(model_write(12'h014, 32'h600DF00D, 4'hF, 3'b001));
    finish_write(resp);
    checks++;
    if (resp !== 2'b00 || pulse !== 16'h0020 || regs_o[5*DATA_W +: DATA_W] !== 32'h600DF00D) begin
      errors++;
      $display("FAIL prot_priv got resp=%b pulse=%h required 00 0020", resp, pulse);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1; AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
    BREADY = 0; ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
    #2;
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_same_edge();
    test_random();
`ifdef AXI4L_REG_SLAVE_PROT_EN
    test_prot();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4l_reg_slave.md
AXI4L_REG_SLAVE -- requirements
Module: axi4l_reg_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning AXI address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning AXI data width; legal values are 32 and 64 only.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, meaning register count, 1..256.
REQ-004 The block SHALL have port ACLK, input, 1 bit: the single clock.
REQ-005 The block SHALL have port ARESETN, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have AW ports AWADDR in ADDR_W, AWPROT in 3, AWVALID in 1, AWREADY out 1.
REQ-007 The block SHALL have W ports WDATA in DATA_W, WSTRB in DATA_W/8, WVALID in 1, WREADY out 1.
REQ-008 The block SHALL have B ports BRESP out 2, BVALID out 1, BREADY in 1.
REQ-009 The block SHALL have AR ports ARADDR in ADDR_W, ARPROT in 3, ARVALID in 1, ARREADY out 1.
REQ-010 The block SHALL have R ports RDATA out DATA_W, RRESP out 2, RVALID out 1, RREADY in 1.
REQ-011 The block SHALL have regs_o, out, NUM_REGS*DATA_W: flat register contents, reg i at bits [i*DATA_W +: DATA_W].
REQ-012 The block SHALL have wr_pulse_o, out, NUM_REGS: one-cycle strobe per register on a committed write.

Function
REQ-013 Register index SHALL be addr[ADDR_W-1 : log2(DATA_W/8)]; low byte-offset bits are ignored.
REQ-014 Index >= NUM_REGS SHALL give response SLVERR (2'b10), write discarded, RDATA all zeros; otherwise OKAY (2'b00).
REQ-015 The write FSM SHALL have states W_IDLE, W_RESP.
REQ-016 In W_IDLE, AW and W SHALL be accepted independently in any order or the same cycle; each is latched and its READY drops until the write commits.
REQ-017 The write SHALL commit on the first edge where both AW and W are held; W_RESP is entered with BVALID=1 in the next cycle.
REQ-018 On commit, only bytes with WSTRB set SHALL update; the wr_pulse_o bit for the register SHALL be high for exactly the cycle after commit, with WSTRB=0 still pulsing.
REQ-019 In W_RESP, BVALID/BRESP SHALL hold stable until BREADY; the FSM returns to W_IDLE after the handshake, with AWREADY/WREADY high in the following cycle.
REQ-020 The read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0).
REQ-021 An AR handshake SHALL register RDATA/RRESP and set RVALID=1 on the next cycle, giving 1-cycle latency; these hold until RREADY, then the FSM returns to R_IDLE.
REQ-022 Read and write FSMs SHALL be independent; a read accepted on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-023 regs_o SHALL reflect a committed write in the cycle after commit.

Reset
REQ-024 On ARESETN low, asynchronously: all registers are 0, both FSMs return to idle, and AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse_o=0.
REQ-025 AWREADY, WREADY and ARREADY SHALL go to 1 on the first edge after ARESETN deasserts; in-flight transactions are lost with no response.

Configuration
REQ-026 With AXI4L_REG_SLAVE_PROT_EN defined, a write with AWPROT[0]=0 (unprivileged) SHALL return SLVERR with no register update and no pulse; reads are unaffected.
REQ-027 Without AXI4L_REG_SLAVE_PROT_EN, AWPROT and ARPROT SHALL be ignored.

Structure
REQ-028 Package axi4l_pkg SHALL hold the resp_e enum (OKAY=2'b00, SLVERR=2'b10) and the state enums for both FSMs.
REQ-029 Sub-module axi4l_reg_slave_wrfsm SHALL contain the AW/W capture and write FSM; read path and storage stay in the top.

Verification
REQ-030 Write addr 0x004, data 0xDEADBEEF, WSTRB 0xF -> BRESP OKAY; regs_o reg1=0xDEADBEEF; wr_pulse_o=0x0002 for one cycle.
REQ-031 Send W three cycles before AW, data 0x12345678, WSTRB 0x3, addr 0x008 on a reg holding 0xFFFFFFFF -> reg2=0xFFFF5678, single B response.
REQ-032 Read addr 0x040 with NUM_REGS=16 -> RRESP SLVERR, RDATA 0; a write there gives BRESP SLVERR and no pulse.
REQ-033 Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and payload stay stable and AWREADY/ARREADY stay 0 throughout.
REQ-034 Same-edge write 0xA5A5A5A5 and read to reg0 holding 0 -> RDATA 0; the next read returns 0xA5A5A5A5.
REQ-035 With macro defined, write AWPROT=3'b000 -> SLVERR, reg unchanged; AWPROT=3'b001 -> OKAY and update.
